vga_line_drawer: RTL and testbench



---
 rtl/vga_line_drawer.sv | 224 ++++++++++++++++++++++
 tb/tb_vga_line_drawer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_drawer.sv
// Drawing engine feeding the colour VGA framebuffer: Bresenham lines or a full-screen
// clear, one registered pixel write per clk50 cycle.
module vga_line_drawer #(
    parameter int HRES = 640,
    parameter int VRES = 480
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [10:0] x0,
    input  logic [10:0] y0,
    input  logic [10:0] x1,
    input  logic [10:0] y1,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        pixel_color,
    output logic        pixel_write,
    output logic        busy,
    output logic        done
);

    // Handshake: start is a level sampled only in IDLE; busy is high from the cycle after
    // acceptance through the done cycle, and done pulses exactly once per finished command.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        DRAW  = 3'd2,
        CLEAR = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [10:0] XLAST = 11'(HRES - 1);
    localparam logic [10:0] YLAST = 11'(VRES - 1);

    state_t state;
    state_t state_next;

    logic [10:0]        lx0, ly0, lx1, ly1;
    logic [10:0]        cx, cy;
    logic signed [12:0] dx, dy, err;
    logic               sx_neg, sy_neg;

    logic signed [12:0] ddx, ddy, setup_dx, setup_dy, err_step;
    logic signed [13:0] e2;
    logic               step_x, step_y, at_end, clr_at_end;
    logic [10:0]        cx_step, cy_step;

    logic [10:0] x_d, y_d;
    logic [7:0]  r_d, g_d, b_d;
    logic        pw_d, busy_d, done_d;

    function automatic logic on_screen(input logic [10:0] px, input logic [10:0] py);
        return ({1'b0, px} < 12'(HRES)) && ({1'b0, py} < 12'(VRES));
    endfunction

    assign ddx      = $signed({2'b00, lx1}) - $signed({2'b00, lx0});
    assign ddy      = $signed({2'b00, ly1}) - $signed({2'b00, ly0});
    assign setup_dx = ddx[12] ? -ddx : ddx;
    assign setup_dy = ddy[12] ? ddy : -ddy;

    assign e2       = $signed({err, 1'b0});
    assign step_x   = e2 >= $signed({dy[12], dy});
    assign step_y   = e2 <= $signed({dx[12], dx});
    assign err_step = err + (step_x ? dy : 13'sd0) + (step_y ? dx : 13'sd0);
    assign cx_step  = !step_x ? cx : (sx_neg ? cx - 11'd1 : cx + 11'd1);
    assign cy_step  = !step_y ? cy : (sy_neg ? cy - 11'd1 : cy + 11'd1);
    assign at_end   = (cx == lx1) && (cy == ly1);

    // The clear finishes once the last pixel is already on the output register.
    assign clr_at_end = pixel_write && (x == XLAST) && (y == YLAST);

    always_ff @(posedge clk50) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = mode ? CLEAR : SETUP;
            SETUP:   state_next = DRAW;
            DRAW:    if (at_end) state_next = DONE;
            CLEAR:   if (clr_at_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output register next values; the cursor shown in DRAW is always the pixel just written.
    always_comb begin
        x_d    = x;
        y_d    = y;
        r_d    = r;
        g_d    = g;
        b_d    = b;
        pw_d   = 1'b0;
        busy_d = busy;
        done_d = 1'b0;
        case (state)
            IDLE: begin
                busy_d = start;
                if (start) begin
                    r_d = r_in;
                    g_d = g_in;
                    b_d = b_in;
                end
            end
            SETUP: begin
                x_d  = lx0;
                y_d  = ly0;
                pw_d = on_screen(lx0, ly0);
            end
            DRAW: begin
                if (at_end) begin
                    done_d = 1'b1;
                end else begin
                    x_d  = cx_step;
                    y_d  = cy_step;
                    pw_d = on_screen(cx_step, cy_step);
                end
            end
            CLEAR: begin
                if (clr_at_end) begin
                    done_d = 1'b1;
                end else begin
                    x_d  = cx;
                    y_d  = cy;
                    pw_d = 1'b1;
                end
            end
            DONE:    busy_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            pixel_write <= 1'b0;
            pixel_color <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            x           <= x_d;
            y           <= y_d;
            r           <= r_d;
            g           <= g_d;
            b           <= b_d;
            pixel_write <= pw_d;
            pixel_color <= pw_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            lx0    <= '0;
            ly0    <= '0;
            lx1    <= '0;
            ly1    <= '0;
            cx     <= '0;
            cy     <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lx0 <= x0;
                        ly0 <= y0;
                        lx1 <= x1;
                        ly1 <= y1;
                        cx  <= '0;
                        cy  <= '0;
                    end
                end
                SETUP: begin
                    dx     <= setup_dx;
                    dy     <= setup_dy;
                    err    <= setup_dx + setup_dy;
                    sx_neg <= !(lx0 < lx1);
                    sy_neg <= !(ly0 < ly1);
                    cx     <= lx0;
                    cy     <= ly0;
                end
                DRAW: begin
                    if (!at_end) begin
                        cx  <= cx_step;
                        cy  <= cy_step;
                        err <= err_step;
                    end
                end
                CLEAR: begin
                    if (!clr_at_end) begin
                        if (cx == XLAST) begin
                            cx <= '0;
                            cy <= cy + 11'd1;
                        end else begin
                            cx <= cx + 11'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_line_drawer.sv
// Bench for vga_line_drawer: directed and random lines against a point-list model,
// reset behaviour, and raster clears on a full-size and a reduced-size instance.
module tb_vga_line_drawer;

    logic        clk50 = 1'b0;
    logic        reset, start, mode;
    logic [10:0] x0, y0, x1, y1;
    logic [7:0]  r_in, g_in, b_in;
    logic [10:0] x, y;
    logic [7:0]  r, g, b;
    logic        pixel_color, pixel_write, busy, done;

    logic        s_start, s_mode;
    logic [10:0] s_x0, s_y0, s_x1, s_y1;
    logic [7:0]  s_r_in, s_g_in, s_b_in;
    logic [10:0] s_x, s_y;
    logic [7:0]  s_r, s_g, s_b;
    logic        s_pixel_color, s_pixel_write, s_busy, s_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [21:0] exp_q[$];

    // clock / reset
    always #10 clk50 = ~clk50;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    vga_line_drawer dut (
        .clk50(clk50), .reset(reset), .start(start), .mode(mode),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .x(x), .y(y), .r(r), .g(g), .b(b),
        .pixel_color(pixel_color), .pixel_write(pixel_write),
        .busy(busy), .done(done)
    );

    vga_line_drawer #(.HRES(20), .VRES(6)) dut_small (
        .clk50(clk50), .reset(reset), .start(s_start), .mode(s_mode),
        .x0(s_x0), .y0(s_y0), .x1(s_x1), .y1(s_y1),
        .r_in(s_r_in), .g_in(s_g_in), .b_in(s_b_in),
        .x(s_x), .y(s_y), .r(s_r), .g(s_g), .b(s_b),
        .pixel_color(s_pixel_color), .pixel_write(s_pixel_write),
        .busy(s_busy), .done(s_done)
    );

    // scoreboard helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    function automatic logic on_scr(input int px, input int py);
        return (px < 640) && (py < 480);
    endfunction

    task automatic push_pt(input int px, input int py);
        exp_q.push_back({11'(px), 11'(py)});
    endtask

    // Reference: the list of points a Bresenham walk visits from (ax,ay) to (bx,by).
    task automatic model_line(input int ax, input int ay, input int bx, input int by);
        int ddx, ddy, sx, sy, err, e2, cx, cy;
        exp_q.delete();
        ddx = (bx > ax) ? bx - ax : ax - bx;
        ddy = -((by > ay) ? by - ay : ay - by);
        sx  = (ax < bx) ? 1 : -1;
        sy  = (ay < by) ? 1 : -1;
        err = ddx + ddy;
        cx  = ax;
        cy  = ay;
        forever begin
            push_pt(cx, cy);
            if (cx == bx && cy == by) break;
            e2 = 2 * err;
            if (e2 >= ddy) begin err += ddy; cx += sx; end
            if (e2 <= ddx) begin err += ddx; cy += sy; end
        end
    endtask

    // driver: issue a line and check every cycle against exp_q
    task automatic run_line(input int ax, input int ay, input int bx, input int by,
                            input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb,
                            input int ghost);
        int n;
        logic [21:0] p;
        logic exp_pw;
        x0 = 11'(ax); y0 = 11'(ay); x1 = 11'(bx); y1 = 11'(by);
        r_in = cr; g_in = cg; b_in = cb; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        x0 = 11'($urandom_range(0, 2047)); y0 = 11'($urandom_range(0, 2047));
        x1 = 11'($urandom_range(0, 2047)); y1 = 11'($urandom_range(0, 2047));
        r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
        chk("busy_t1", busy, 1);
        chk("pw_t1", pixel_write, 0);
        chk("r_latched", r, cr);
        chk("g_latched", g, cg);
        chk("b_latched", b, cb);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            if (k == ghost) begin
                start = 1'b1;
                mode  = 1'($urandom_range(0, 1));
            end
            tick();
            start = 1'b0;
            p = exp_q.pop_front();
            exp_pw = on_scr(int'(p[21:11]), int'(p[10:0]));
            chk("line_pw", pixel_write, exp_pw);
            chk("line_pc", pixel_color, exp_pw);
            chk("line_x", x, p[21:11]);
            chk("line_y", y, p[10:0]);
            chk("line_busy", busy, 1);
            chk("line_done", done, 0);
        end
        tick();
        chk("end_done", done, 1);
        chk("end_busy", busy, 1);
        chk("end_pw", pixel_write, 0);
        chk("end_colour", {r, g, b}, {cr, cg, cb});
        start = 1'b1;
        mode  = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        tick();
        chk("idle_busy2", busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; r_in = '0; g_in = '0; b_in = '0;
        s_start = 1'b0; s_mode = 1'b1;
        s_x0 = '0; s_y0 = '0; s_x1 = '0; s_y1 = '0; s_r_in = '0; s_g_in = '0; s_b_in = '0;
        tick();
        tick();
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_rgb", {r, g, b}, 0);
        chk("rst_pw", pixel_write, 0);
        chk("rst_pc", pixel_color, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_small_busy", s_busy, 0);
        reset = 1'b0;
        tick();

        // horizontal, with a second start ignored mid-line
        exp_q.delete();
        for (int i = 10; i <= 14; i++) push_pt(i, 5);
        run_line(10, 5, 14, 5, 8'hFF, 8'h00, 8'h00, 2);

        // steep
        begin
            int sxs[8];
            sxs = '{0, 0, 1, 1, 2, 2, 3, 3};
            exp_q.delete();
            for (int i = 0; i < 8; i++) push_pt(sxs[i], i);
        end
        run_line(0, 0, 3, 7, 8'h11, 8'h22, 8'h33, -1);

        // reverse direction
        exp_q.delete();
        for (int i = 5; i >= 2; i--) push_pt(i, 5);
        run_line(5, 5, 2, 5, 8'h44, 8'h55, 8'h66, 0);

        // single point
        exp_q.delete();
        push_pt(7, 9);
        run_line(7, 9, 7, 9, 8'h77, 8'h88, 8'h99, -1);

        // clipping at the right edge
        exp_q.delete();
        for (int i = 637; i <= 642; i++) push_pt(i, 10);
        run_line(637, 10, 642, 10, 8'hAA, 8'hBB, 8'hCC, 3);

        // random lines, some partly off-screen
        for (int t = 0; t < 16; t++) begin
            int ax, ay, bx, by;
            ax = $urandom_range(0, 700);
            ay = $urandom_range(0, 520);
            bx = $urandom_range(0, 700);
            by = $urandom_range(0, 520);
            model_line(ax, ay, bx, by);
            run_line(ax, ay, bx, by, 8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 3));
        end

        // reset in the middle of a line
        x0 = 11'd0; y0 = 11'd0; x1 = 11'd100; y1 = 11'd50; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("midline_pw_pre", pixel_write, 1);
        reset = 1'b1;
        tick();
        chk("midrst_pw", pixel_write, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_after_done", done, 0);
            chk("midrst_after_busy", busy, 0);
        end

        // full-size clear, interrupted by reset after 1000 writes
        mode = 1'b1; r_in = 8'h12; g_in = 8'h34; b_in = 8'h56; start = 1'b1;
        tick();
        start = 1'b0;
        chk("clr_busy_t1", busy, 1);
        chk("clr_pw_t1", pixel_write, 0);
        for (int i = 0; i < 1000; i++) begin
            tick();
            chk("clr_pw", pixel_write, 1);
            chk("clr_x", x, i % 640);
            chk("clr_y", y, i / 640);
        end
        chk("clr_colour", {r, g, b}, 24'h123456);
        reset = 1'b1;
        tick();
        chk("clr_rst_busy", busy, 0);
        chk("clr_rst_pw", pixel_write, 0);
        reset = 1'b0;
        tick();

        // complete clear on the reduced 20x6 instance
        s_r_in = 8'($urandom); s_g_in = 8'($urandom); s_b_in = 8'($urandom);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("sclr_busy_t1", s_busy, 1);
        for (int i = 0; i < 120; i++) begin
            tick();
            chk("sclr_pw", s_pixel_write, 1);
            chk("sclr_x", s_x, i % 20);
            chk("sclr_y", s_y, i / 20);
            chk("sclr_done", s_done, 0);
        end
        chk("sclr_colour", {s_r, s_g, s_b}, {s_r_in, s_g_in, s_b_in});
        tick();
        chk("sclr_end_done", s_done, 1);
        chk("sclr_end_busy", s_busy, 1);
        chk("sclr_end_pw", s_pixel_write, 0);
        tick();
        chk("sclr_idle_busy", s_busy, 0);
        chk("sclr_idle_done", s_done, 0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
